// File: rtl/sprite_collision_engine.sv
// Sprite collision engine: time-multiplexed AABB test of the dino box against N_OBJ
// obstacle boxes, one channel per cycle, with a sticky hit flag and first-hit index.
module sprite_collision_engine #(
  parameter int unsigned N_OBJ  = 4,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 9,
  parameter int unsigned MARGIN = 2,
  localparam int unsigned IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   enable,
  input  logic                   restart,
  input  logic [X_W-1:0]         dino_x,
  input  logic [Y_W-1:0]         dino_y,
  input  logic [X_W-1:0]         dino_w,
  input  logic [Y_W-1:0]         dino_h,
  input  logic [N_OBJ*X_W-1:0]   obj_x,
  input  logic [N_OBJ*Y_W-1:0]   obj_y,
  input  logic [N_OBJ*X_W-1:0]   obj_w,
  input  logic [N_OBJ*Y_W-1:0]   obj_h,
  input  logic [N_OBJ-1:0]       obj_valid,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_idx
);

  localparam int unsigned XE_W = X_W + 1;
  localparam int unsigned YE_W = Y_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hit_q, hit_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;

  logic [X_W-1:0]       dx_q, dx_d, dw_q, dw_d;
  logic [Y_W-1:0]       dy_q, dy_d, dh_q, dh_d;
  logic [N_OBJ*X_W-1:0] ox_q, ox_d, ow_q, ow_d;
  logic [N_OBJ*Y_W-1:0] oy_q, oy_d, oh_q, oh_d;
  logic [N_OBJ-1:0]     ov_q, ov_d;

  logic                 snap_load;
  logic [X_W-1:0]       cur_ox, cur_ow;
  logic [Y_W-1:0]       cur_oy, cur_oh;
  logic                 cur_ov;
  logic                 pass;

  assign busy      = busy_q;
  assign scan_done = done_q;
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;

  // Select the snapshotted obstacle currently under test.
  always_comb begin
    cur_ox = '0;
    cur_ow = '0;
    cur_oy = '0;
    cur_oh = '0;
    cur_ov = 1'b0;
    for (int i = 0; i < int'(N_OBJ); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_ox = ox_q[i*X_W +: X_W];
        cur_ow = ow_q[i*X_W +: X_W];
        cur_oy = oy_q[i*Y_W +: Y_W];
        cur_oh = oh_q[i*Y_W +: Y_W];
        cur_ov = ov_q[i];
      end
    end
  end

  // Overlap test in one extra bit so edge sums cannot wrap; thin boxes never hit.
  always_comb begin
    logic [XE_W-1:0] mx;
    logic [YE_W-1:0] my;
    logic            size_ok, x_ok, y_ok;
    mx      = XE_W'(MARGIN);
    my      = YE_W'(MARGIN);
    size_ok = (XE_W'(dw_q) > mx) && (XE_W'(cur_ow) > mx) &&
              (YE_W'(dh_q) > my) && (YE_W'(cur_oh) > my);
    x_ok    = (XE_W'(dx_q) + mx < XE_W'(cur_ox) + XE_W'(cur_ow)) &&
              (XE_W'(cur_ox) + mx < XE_W'(dx_q) + XE_W'(dw_q));
    y_ok    = (YE_W'(dy_q) + my < YE_W'(cur_oy) + YE_W'(cur_oh)) &&
              (YE_W'(cur_oy) + my < YE_W'(dy_q) + YE_W'(dh_q));
    pass    = cur_ov && size_ok && x_ok && y_ok;
  end

  // Next-state, hit latching and snapshot capture; restart overrides everything.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    snap_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && enable && !restart) begin
          state_d   = S_SCAN;
          idx_d     = '0;
          snap_load = 1'b1;
        end
      end
      S_SCAN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (pass && !hit_q) begin
            hit_d     = 1'b1;
            hit_idx_d = idx_q;
          end
          if (idx_q == IDX_W'(N_OBJ - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (restart) begin
      state_d   = S_IDLE;
      hit_d     = 1'b0;
      hit_idx_d = '0;
    end
    busy_d = (state_d == S_SCAN);
    done_d = (state_d == S_DONE);
    dx_d   = snap_load ? dino_x    : dx_q;
    dy_d   = snap_load ? dino_y    : dy_q;
    dw_d   = snap_load ? dino_w    : dw_q;
    dh_d   = snap_load ? dino_h    : dh_q;
    ox_d   = snap_load ? obj_x     : ox_q;
    oy_d   = snap_load ? obj_y     : oy_q;
    ow_d   = snap_load ? obj_w     : ow_q;
    oh_d   = snap_load ? obj_h     : oh_q;
    ov_d   = snap_load ? obj_valid : ov_q;
  end

  // State, output and snapshot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      dw_q      <= '0;
      dh_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      ow_q      <= '0;
      oh_q      <= '0;
      ov_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      dw_q      <= dw_d;
      dh_q      <= dh_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      ow_q      <= ow_d;
      oh_q      <= oh_d;
      ov_q      <= ov_d;
    end
  end

endmodule

// File: tb/tb_sprite_collision_engine.sv
// Self-checking bench for sprite_collision_engine against an integer-arithmetic box model.
module tb_sprite_collision_engine;

  localparam int unsigned N     = 4;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned M     = 2;
  localparam int unsigned IDX_W = 2;

  logic                 clk = 1'b0;
  logic                 rst, tick, enable, restart;
  logic [X_W-1:0]       dino_x, dino_w;
  logic [Y_W-1:0]       dino_y, dino_h;
  logic [N*X_W-1:0]     obj_x, obj_w;
  logic [N*Y_W-1:0]     obj_y, obj_h;
  logic [N-1:0]         obj_valid;
  logic                 busy, scan_done, hit;
  logic [IDX_W-1:0]     hit_idx;

  int dxa, dya, dwa, dha;
  int oxa [N];
  int oya [N];
  int owa [N];
  int oha [N];
  bit ova [N];

  bit exp_hit;
  int exp_idx;
  int n_checks = 0;
  int n_fail   = 0;

  sprite_collision_engine #(.N_OBJ(N), .X_W(X_W), .Y_W(Y_W), .MARGIN(M)) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .restart(restart),
    .dino_x(dino_x), .dino_y(dino_y), .dino_w(dino_w), .dino_h(dino_h),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
    .obj_valid(obj_valid), .busy(busy), .scan_done(scan_done),
    .hit(hit), .hit_idx(hit_idx)
  );

  always #5 clk = ~clk;

  // Pack the bench's integer box arrays onto the DUT buses.
  always_comb begin
    dino_x    = X_W'(dxa);
    dino_y    = Y_W'(dya);
    dino_w    = X_W'(dwa);
    dino_h    = Y_W'(dha);
    obj_x     = '0;
    obj_y     = '0;
    obj_w     = '0;
    obj_h     = '0;
    obj_valid = '0;
    for (int i = 0; i < int'(N); i++) begin
      obj_x[i*X_W +: X_W] = X_W'(oxa[i]);
      obj_y[i*Y_W +: Y_W] = Y_W'(oya[i]);
      obj_w[i*X_W +: X_W] = X_W'(owa[i]);
      obj_h[i*Y_W +: Y_W] = Y_W'(oha[i]);
      obj_valid[i]        = ova[i];
    end
  end

  function automatic bit ref_hits(int i);
    if (!ova[i]) return 1'b0;
    if (dwa <= int'(M) || dha <= int'(M) || owa[i] <= int'(M) || oha[i] <= int'(M)) return 1'b0;
    return (dxa + int'(M) < oxa[i] + owa[i]) && (oxa[i] + int'(M) < dxa + dwa) &&
           (dya + int'(M) < oya[i] + oha[i]) && (oya[i] + int'(M) < dya + dha);
  endfunction

  // A completed scan latches the lowest overlapping channel unless a hit is already held.
  function automatic void model_scan();
    if (exp_hit) return;
    for (int i = 0; i < int'(N); i++) begin
      if (ref_hits(i)) begin
        exp_hit = 1'b1;
        exp_idx = i;
        return;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dino(input int x, input int y, input int w, input int h);
    dxa = x; dya = y; dwa = w; dha = h;
  endtask

  task automatic set_obj(input int i, input bit v, input int x, input int y, input int w, input int h);
    ova[i] = v; oxa[i] = x; oya[i] = y; owa[i] = w; oha[i] = h;
  endtask

  task automatic clear_objs();
    for (int i = 0; i < int'(N); i++) set_obj(i, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic randomize_boxes();
    dxa = int'($urandom_range(0, 1023));
    dya = int'($urandom_range(0, 511));
    dwa = int'($urandom_range(0, 60));
    dha = int'($urandom_range(0, 60));
    for (int i = 0; i < int'(N); i++) begin
      ova[i] = 1'($urandom_range(0, 1));
      oxa[i] = (dxa + int'($urandom_range(0, 120)) + 1024 - 60) % 1024;
      oya[i] = (dya + int'($urandom_range(0, 100)) + 512 - 50) % 512;
      owa[i] = int'($urandom_range(0, 60));
      oha[i] = int'($urandom_range(0, 60));
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    exp_hit = 1'b0;
    exp_idx = 0;
  endtask

  // Pulse tick and watch a bounded window; records first scan_done offset and busy shape.
  task automatic do_scan(input bit scramble, output int done_at, output int n_done, output bit busy_ok);
    done_at = -1;
    n_done  = 0;
    busy_ok = 1'b1;
    model_scan();
    tick = 1'b1;
    step();
    tick = 1'b0;
    if (scramble) randomize_boxes();
    for (int k = 1; k <= int'(N) + 4; k++) begin
      if (busy !== (k <= int'(N))) busy_ok = 1'b0;
      if (scan_done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b exp 0", scan_done); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b exp 0", hit); end
    n_checks++; if (hit_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d exp 0", hit_idx); end
    rst = 1'b0;
    exp_hit = 1'b0;
    exp_idx = 0;
    step();
  endtask

  task automatic test_basic();
    int d, n; bit b;
    set_dino(60, 372, 42, 45);
    clear_objs();
    set_obj(2, 1'b1, 80, 380, 17, 35);
    enable = 1'b1;
    do_scan(1'b0, d, n, b);
    n_checks++; if (d != int'(N) + 1) begin n_fail++; $display("FAIL basic_latency: got %0d exp %0d", d, N + 1); end
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d exp 1", n); end
    n_checks++; if (!b) begin n_fail++; $display("FAIL basic_busy_window: got 0 exp 1"); end
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL basic_hit: got %0b exp %0b", hit, exp_hit); end
    n_checks++; if (hit_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL basic_idx: got %0d exp %0d", hit_idx, exp_idx); end
  endtask

  task automatic test_edge();
    int d, n; bit b;
    do_restart();
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL edge_restart_hit: got %0b exp 0", hit); end
    set_dino(60, 372, 42, 45);
    clear_objs();
    set_obj(0, 1'b1, 60 + 42 - 2, 380, 17, 35);
    do_scan(1'b0, d, n, b);
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL edge_touch_hit: got %0b exp %0b", hit, exp_hit); end
    oxa[0] = 60 + 42 - 3;
    do_scan(1'b0, d, n, b);
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL edge_overlap_hit: got %0b exp %0b", hit, exp_hit); end
    n_checks++; if (hit_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL edge_overlap_idx: got %0d exp %0d", hit_idx, exp_idx); end
  endtask

  task automatic test_two_hits();
    int d, n; bit b;
    do_restart();
    set_dino(60, 372, 42, 45);
    clear_objs();
    set_obj(1, 1'b1, 80, 380, 17, 35);
    set_obj(3, 1'b1, 70, 390, 10, 20);
    do_scan(1'b0, d, n, b);
    n_checks++; if (hit_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL two_hits_idx: got %0d exp %0d", hit_idx, exp_idx); end
    ova[1] = 1'b0;
    do_scan(1'b0, d, n, b);
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL sticky_hit: got %0b exp %0b", hit, exp_hit); end
    n_checks++; if (hit_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL sticky_idx: got %0d exp %0d", hit_idx, exp_idx); end
  endtask

  task automatic test_back_to_back();
    int n, d;
    n = 0; d = -1;
    model_scan();
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 1; k <= int'(N) + 5; k++) begin
      if (k == 2) tick = 1'b1;
      if (k == 3) tick = 1'b0;
      if (scan_done === 1'b1) begin n++; if (d < 0) d = k; end
      step();
    end
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d exp 1", n); end
    n_checks++; if (d != int'(N) + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d exp %0d", d, N + 1); end
    n = 0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    enable = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b exp 0", busy); end
    for (int k = 0; k < int'(N) + 3; k++) begin
      if (scan_done === 1'b1) n++;
      step();
    end
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL abort_done_count: got %0d exp 0", n); end
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL abort_hit_kept: got %0b exp %0b", hit, exp_hit); end
    enable = 1'b1;
    step();
  endtask

  task automatic test_restart_race();
    int d, n; bit b;
    n = 0;
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL race_pre_hit: got %0b exp %0b", hit, exp_hit); end
    set_dino(60, 372, 42, 45);
    clear_objs();
    set_obj(0, 1'b1, 80, 380, 17, 35);
    tick = 1'b1;
    step();
    tick = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    exp_hit = 1'b0;
    exp_idx = 0;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL race_hit: got %0b exp 0", hit); end
    n_checks++; if (hit_idx !== '0) begin n_fail++; $display("FAIL race_idx: got %0d exp 0", hit_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL race_busy: got %0b exp 0", busy); end
    for (int k = 0; k < int'(N) + 3; k++) begin
      if (scan_done === 1'b1) n++;
      step();
    end
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL race_done_count: got %0d exp 0", n); end
    tick = 1'b1;
    step();
    tick = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL race_fresh_hit: got %0b exp 0", hit); end
    step();
    do_scan(1'b0, d, n, b);
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL race_rescan_hit: got %0b exp %0b", hit, exp_hit); end
    n_checks++; if (hit_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL race_rescan_idx: got %0d exp %0d", hit_idx, exp_idx); end
  endtask

  task automatic test_overflow();
    int d, n; bit b;
    do_restart();
    set_dino(1000, 100, 40, 50);
    clear_objs();
    set_obj(2, 1'b1, 1010, 120, 20, 30);
    do_scan(1'b0, d, n, b);
    n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL overflow_hit: got %0b exp %0b", hit, exp_hit); end
    n_checks++; if (hit_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL overflow_idx: got %0d exp %0d", hit_idx, exp_idx); end
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_hit = 1'b0;
    exp_idx = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b exp 0", busy); end
    n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %0b exp 0", scan_done); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL midrst_hit: got %0b exp 0", hit); end
    n_checks++; if (hit_idx !== '0) begin n_fail++; $display("FAIL midrst_idx: got %0d exp 0", hit_idx); end
    n = 0;
    for (int k = 0; k < int'(N) + 3; k++) begin
      if (scan_done === 1'b1 || busy === 1'b1) n++;
      step();
    end
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL midrst_idle: got %0d active cycles exp 0", n); end
  endtask

  task automatic test_random();
    int d, n; bit b;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) do_restart();
      randomize_boxes();
      do_scan(1'b1, d, n, b);
      n_checks++; if (d != int'(N) + 1 || n != 1 || !b) begin
        n_fail++; $display("FAIL rand_timing it=%0d: done_at %0d count %0d busy_ok %0b exp %0d 1 1", it, d, n, b, N + 1);
      end
      n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL rand_hit it=%0d: got %0b exp %0b", it, hit, exp_hit); end
      n_checks++; if (hit_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL rand_idx it=%0d: got %0d exp %0d", it, hit_idx, exp_idx); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    tick    = 1'b0;
    enable  = 1'b0;
    restart = 1'b0;
    set_dino(0, 0, 0, 0);
    clear_objs();
    exp_hit = 1'b0;
    exp_idx = 0;
    test_reset();
    test_basic();
    test_edge();
    test_two_hits();
    test_back_to_back();
    test_restart_race();
    test_overflow();
    enable = 1'b1;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
